// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - Boot-loadable 1024x32 instruction ROM with registered fetch buffer
// Optional feature macro: INST_ROM_MISALIGN_CHECK_EN (flags fetches with rom_addr[1:0] != 0)

module inst_rom (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_ce,
    input  logic [31:0] rom_addr,
    output logic [31:0] rom_data,
    output logic        rom_stallreq,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        boot_done,
    output logic        rom_misalign
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Loader assembly state: bytes already received for the current word
    logic [1:0]  byte_cnt_q;
    logic [1:0]  byte_cnt_d;
    logic [9:0]  word_cnt_q;
    logic [9:0]  word_cnt_d;
    logic [23:0] word_buf_q;
    logic [23:0] word_buf_d;

    // Fetch buffer: one cached word of the array
    logic [9:0]  addr_q;
    logic [9:0]  addr_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        valid_q;
    logic        valid_d;

    // Instruction storage; contents survive reset by design
    logic [31:0] mem_q [1024];

    logic        mem_we;
    logic [31:0] asm_word;
    logic        ld_accept;
    logic [9:0]  fetch_idx;
    logic [31:0] rd_data;
    logic        fetch_hit;
    logic        fetch_misaligned;

    assign fetch_idx = rom_addr[11:2];
    assign rd_data   = mem_q[fetch_idx];
    assign fetch_hit = valid_q && (addr_q == fetch_idx);
    assign ld_accept = (state_q == ST_LOAD) && ld_valid;

`ifdef INST_ROM_MISALIGN_CHECK_EN
    assign fetch_misaligned = (rom_addr[1:0] != 2'b00);
    logic  unused_addr_bits;
    assign unused_addr_bits = ^rom_addr[31:12];
`else
    assign fetch_misaligned = 1'b0;
    logic  unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr[31:12], rom_addr[1:0]};
`endif

    // Merge the incoming byte into the partial word, big-endian, zero-padding the tail
    always_comb begin
        asm_word = 32'h0;
        case (byte_cnt_q)
            2'd0: asm_word = {ld_byte, 24'h0};
            2'd1: asm_word = {word_buf_q[23:16], ld_byte, 16'h0};
            2'd2: asm_word = {word_buf_q[23:8], ld_byte, 8'h0};
            default: asm_word = {word_buf_q, ld_byte};
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: last loader byte starts RUN, ld_start pulse returns to LOAD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (ld_accept && ld_last) state_d = ST_RUN;
            ST_RUN:  if (ld_start)             state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    // Outputs: stall the core while loading or on a fetch buffer miss
    always_comb begin
        rom_data     = 32'h0;
        rom_stallreq = 1'b0;
        ld_ready     = 1'b0;
        boot_done    = 1'b0;
        rom_misalign = 1'b0;
        case (state_q)
            ST_LOAD: begin
                ld_ready     = 1'b1;
                rom_stallreq = 1'b1;
            end
            ST_RUN: begin
                boot_done = 1'b1;
                if (rom_ce) begin
                    if (fetch_misaligned) begin
                        rom_misalign = 1'b1;
                    end else if (fetch_hit) begin
                        rom_data = data_q;
                    end else begin
                        rom_stallreq = 1'b1;
                    end
                end
            end
            default: begin
                ld_ready     = 1'b1;
                rom_stallreq = 1'b1;
            end
        endcase
    end

    // Datapath next-state: loader counters, array write strobe and fetch buffer fill
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_buf_d = word_buf_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        mem_we     = 1'b0;

        if (state_q == ST_LOAD) begin
            if (ld_accept) begin
                word_buf_d = asm_word[31:8];
                byte_cnt_d = byte_cnt_q + 2'd1;
                if ((byte_cnt_q == 2'd3) || ld_last) begin
                    mem_we     = !rst;
                    word_cnt_d = word_cnt_q + 10'd1;
                    valid_d    = 1'b0;
                end
                if (ld_last) begin
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 10'd0;
                    word_buf_d = 24'h0;
                end
            end
        end else begin
            if (ld_start) begin
                byte_cnt_d = 2'd0;
                word_cnt_d = 10'd0;
                word_buf_d = 24'h0;
                valid_d    = 1'b0;
            end else if (rom_ce && !fetch_misaligned && !fetch_hit) begin
                addr_d  = fetch_idx;
                data_d  = rd_data;
                valid_d = 1'b1;
            end
        end
    end

    // Loader and fetch buffer registers; reset discards any partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 10'd0;
            word_buf_q <= 24'h0;
            addr_q     <= 10'd0;
            data_q     <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_buf_q <= word_buf_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    // Array write port, driven by the loader word counter
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_cnt_q] <= asm_word;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// tb/tb_inst_rom.sv - Directed self-checking bench for inst_rom

module tb_inst_rom;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_stallreq;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        boot_done;
    logic        rom_misalign;

    int n_total;
    int n_pass;

    inst_rom dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .rom_stallreq (rom_stallreq),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .boot_done    (boot_done),
        .rom_misalign (rom_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        send_byte(w[31:24], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[7:0],   last);
    endtask

    task automatic fetch(input logic [31:0] a, input logic exp_stall,
                         input logic [31:0] exp_d, input string nm);
        @(negedge clk);
        rom_ce   = 1'b1;
        rom_addr = a;
        #1;
        n_total++;
        if (rom_stallreq !== exp_stall)
            $display("FAIL %s first_stall: got %0b want %0b", nm, rom_stallreq, exp_stall);
        else n_pass++;
        if (exp_stall) begin
            n_total++;
            if (rom_data !== 32'h0)
                $display("FAIL %s data_during_stall: got %08h want 00000000", nm, rom_data);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        n_total++;
        if (rom_stallreq !== 1'b0)
            $display("FAIL %s stall_after: got %0b want 0", nm, rom_stallreq);
        else n_pass++;
        n_total++;
        if (rom_data !== exp_d)
            $display("FAIL %s data: got %08h want %08h", nm, rom_data, exp_d);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1; rom_ce = 1'b0; rom_addr = 32'h0; ld_start = 1'b0;
        ld_valid = 1'b0; ld_byte = 8'h0; ld_last = 1'b0;
        #12;
        n_total++;
        if ({ld_ready, rom_stallreq, boot_done, rom_misalign} !== 4'b1100)
            $display("FAIL reset_flags: got %04b want 1100", {ld_ready, rom_stallreq, boot_done, rom_misalign});
        else n_pass++;
        n_total++;
        if (rom_data !== 32'h0)
            $display("FAIL reset_data: got %08h want 00000000", rom_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_load;
        send_byte(8'h34, 1'b0);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        send_byte(8'h00, 1'b0);
        n_total++;
        if (boot_done !== 1'b0 || ld_ready !== 1'b1)
            $display("FAIL basic_midload: got boot=%0b rdy=%0b want boot=0 rdy=1", boot_done, ld_ready);
        else n_pass++;
        send_byte(8'h01, 1'b1);
        n_total++;
        if (boot_done !== 1'b1 || ld_ready !== 1'b0)
            $display("FAIL basic_boot: got boot=%0b rdy=%0b want boot=1 rdy=0", boot_done, ld_ready);
        else n_pass++;
        n_total++;
        if (rom_stallreq !== 1'b0 || rom_data !== 32'h0)
            $display("FAIL basic_ce_off: got stall=%0b data=%08h want 0/00000000", rom_stallreq, rom_data);
        else n_pass++;
        fetch(32'h0, 1'b1, 32'h34020001, "basic_fetch0");
    endtask

    task automatic test_ld_start;
        @(negedge clk);
        ld_start = 1'b1;
        rom_ce   = 1'b0;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        n_total++;
        if ({ld_ready, rom_stallreq, boot_done} !== 3'b110 || rom_data !== 32'h0)
            $display("FAIL ld_start_reenter: got rdy/stall/boot=%03b data=%08h want 110/00000000",
                     {ld_ready, rom_stallreq, boot_done}, rom_data);
        else n_pass++;
    endtask

    task automatic test_partial_and_alias;
        test_ld_start();
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b0); send_byte(8'hFF, 1'b1);
        fetch(32'h0,    1'b1, 32'hAABBCCDD, "seq_0x0");
        fetch(32'h4,    1'b1, 32'hEEFF0000, "seq_0x4");
        fetch(32'h4,    1'b0, 32'hEEFF0000, "seq_0x4_repeat");
        fetch(32'h1004, 1'b0, 32'hEEFF0000, "seq_0x1004_alias");
    endtask

    task automatic test_reset_midload;
        test_ld_start();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++;
        if ({ld_ready, rom_stallreq, boot_done} !== 3'b110)
            $display("FAIL midload_reset_flags: got %03b want 110", {ld_ready, rom_stallreq, boot_done});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        send_word(32'h11223344, 1'b1);
        fetch(32'h0, 1'b1, 32'h11223344, "midload_word0");
        fetch(32'h4, 1'b1, 32'hEEFF0000, "midload_word1_kept");
    endtask

    task automatic test_misalign;
`ifdef INST_ROM_MISALIGN_CHECK_EN
        @(negedge clk);
        rom_ce   = 1'b1;
        rom_addr = 32'h2;
        #1;
        n_total++;
        if ({rom_misalign, rom_stallreq} !== 2'b10 || rom_data !== 32'h0)
            $display("FAIL misalign_flag: got mis/stall=%02b data=%08h want 10/00000000",
                     {rom_misalign, rom_stallreq}, rom_data);
        else n_pass++;
        @(negedge clk);
        rom_addr = 32'h0;
        #1;
        n_total++;
        if (rom_misalign !== 1'b0 || rom_stallreq !== 1'b1)
            $display("FAIL misalign_nobuf: got mis=%0b stall=%0b want 0/1", rom_misalign, rom_stallreq);
        else n_pass++;
`else
        fetch(32'h2, 1'b1, 32'h11223344, "misalign_ignored");
        n_total++;
        if (rom_misalign !== 1'b0)
            $display("FAIL misalign_tied: got %0b want 0", rom_misalign);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap_and_ce_off;
        test_ld_start();
        for (int k = 0; k < 1024; k++) send_word(32'hC0DE0000 | k, 1'b0);
        send_word(32'hFEED1025, 1'b1);
        fetch(32'h0,    1'b1, 32'hFEED1025, "wrap_word0");
        fetch(32'h4,    1'b1, 32'hC0DE0001, "wrap_word1");
        fetch(32'hFFC,  1'b1, 32'hC0DE03FF, "wrap_word1023");
        fetch(32'h3FFC, 1'b0, 32'hC0DE03FF, "wrap_alias_hit");
        @(negedge clk);
        rom_ce = 1'b0;
        #1;
        n_total++;
        if (rom_stallreq !== 1'b0 || rom_data !== 32'h0)
            $display("FAIL ce_off: got stall=%0b data=%08h want 0/00000000", rom_stallreq, rom_data);
        else n_pass++;
        @(negedge clk);
        rom_ce   = 1'b1;
        rom_addr = 32'hFFC;
        #1;
        n_total++;
        if (rom_stallreq !== 1'b0 || rom_data !== 32'hC0DE03FF)
            $display("FAIL ce_off_buffer_kept: got stall=%0b data=%08h want 0/C0DE03FF", rom_stallreq, rom_data);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_basic_load();
        test_partial_and_alias();
        test_reset_midload();
        test_misalign();
        test_wrap_and_ce_off();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
